alu_sched: RTL

Request scheduler that shares a single 8-bit ALU datapath (add, subtract, AND, XOR) between `NREQ` independent requesters. Arbitration is round-robin. Each accepted operation is captured, computed in one cycle and held in a registered response port until the consumer takes it. The block sits between the requesting engines and the downstream result consumer, and is the only path to the ALU.

---
 rtl/alu_sched_pkg.sv | 35 +++
 rtl/alu_rr_arbiter.sv | 42 ++++
 rtl/alu_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the alu_sched request scheduler: opcode encodings,
// FSM state encoding and the single-cycle ALU evaluation helpers.
// No ports; imported by alu_sched and alu_rr_arbiter.
package alu_sched_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Unknown opcodes fall back to subtract.
  function automatic logic [7:0] alu_result(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [3:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return a - b;
    endcase
  endfunction

  // Carry out of the 9-bit sum, reported for every opcode.
  function automatic logic alu_carry(input logic [7:0] a,
                                     input logic [7:0] b);
    return ({1'b0, a} + {1'b0, b}) > 9'd255;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter: picks the first set request after last_grant, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none of its own; the parent gates when the grant is used.
// Ports: req (request vector), last_grant (index of previous winner, held by
//        the parent), grant (one-hot winner, zero if no request), grant_idx.
module alu_rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic           found;
  logic [IDW-1:0] cand;
  int             pos;

  // Scan offsets 1..NREQ from the previous winner; the previous winner itself
  // is considered last, which gives it the lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    pos       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = int'(last_grant) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      cand = IDW'(pos);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one 8-bit ALU (add/sub/and/xor) between NREQ requesters, round-robin.
// Latency: accept cycle, execute cycle, then rsp_valid from the third cycle on.
// Backpressure: one operation in flight; req_ready stays low until rsp taken.
// Ports: clk, rst_n (async, active-low); req_valid/req_ready per requester
//        with packed req_a/req_b (8 bits each) and req_op (4 bits each);
//        rsp_valid/rsp_ready with rsp_data, rsp_carry, rsp_id.
// Optional: ALU_SCHED_STATS_EN adds saturating 16-bit grant counters read
//        combinationally through stat_sel/stat_count.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [4*NREQ-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_carry,
  output logic [IDW-1:0]    rsp_id
`ifdef ALU_SCHED_STATS_EN
  ,
  input  logic [IDW-1:0]    stat_sel,
  output logic [15:0]       stat_count
`endif
);

  state_t          state;
  logic [7:0]      cap_a;
  logic [7:0]      cap_b;
  logic [3:0]      cap_op;
  logic [IDW-1:0]  cap_id;
  logic [IDW-1:0]  last_grant;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            accept;
  logic [7:0]      sel_a;
  logic [7:0]      sel_b;
  logic [3:0]      sel_op;

  alu_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // rst_n gating keeps req_ready low for the whole reset assertion, even
  // though the state register already reads IDLE.
  assign accept    = (state == IDLE) && (|req_valid);
  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign rsp_valid = (state == RESP);

  // One-hot AND-OR mux of the winner's operands.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a  = sel_a  | ({8{grant[i]}} & req_a[8*i +: 8]);
      sel_b  = sel_b  | ({8{grant[i]}} & req_b[8*i +: 8]);
      sel_op = sel_op | ({4{grant[i]}} & req_op[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_op     <= '0;
      cap_id     <= '0;
      last_grant <= IDW'(NREQ - 1);
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_a      <= sel_a;
            cap_b      <= sel_b;
            cap_op     <= sel_op;
            cap_id     <= grant_idx;
            last_grant <= grant_idx;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_result(cap_a, cap_b, cap_op);
          rsp_carry <= alu_carry(cap_a, cap_b);
          rsp_id    <= cap_id;
          state     <= RESP;
        end
        RESP: begin
          // Response registers are only written in EXEC, so they hold here.
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SCHED_STATS_EN
  logic [15:0] grant_cnt [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
    end else if (accept && grant_cnt[grant_idx] != 16'hFFFF) begin
      grant_cnt[grant_idx] <= grant_cnt[grant_idx] + 16'd1;
    end
  end

  assign stat_count = (int'(stat_sel) < NREQ) ? grant_cnt[stat_sel] : 16'd0;
`endif

endmodule
